// File: rtl/async_fifo_rd_drain.sv
// async_fifo_rd_drain: read-domain FIFO drain into a 2-entry valid/ready output buffer with delivery stats
module async_fifo_rd_drain #(
   parameter int D_SIZE = 8,
   parameter int CNT_W = 16
) (
   input  logic              r_clk,
   input  logic              r_rst,
   input  logic [D_SIZE-1:0] r_data,
   input  logic              r_empty,
   output logic              r_inc,
   input  logic              enable,
   output logic [D_SIZE-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic              clr_stats,
   output logic [CNT_W-1:0]  word_count,
   output logic [D_SIZE-1:0] checksum,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ACTIVE, STOPPING} state_t;
   state_t state, state_nxt;
   logic [D_SIZE-1:0] ent [2];
   logic [1:0] occ, occ_nxt;
   logic hd, infl, pop;
   assign out_valid = occ != 2'd0;
   assign out_data = ent[hd];
   assign pop = out_valid && out_ready;
   assign occ_nxt = occ + {1'b0, infl} - {1'b0, pop};
   // occ_nxt already counts the in-flight word and this cycle's pop, so a new pop always has a slot
   assign r_inc = enable && !r_empty && state == ACTIVE && occ_nxt < 2'd2;
   assign busy = state != IDLE;
   always_comb begin
      state_nxt = state;
      if (state == IDLE && enable) state_nxt = ACTIVE;
      else if (state == ACTIVE && !enable) state_nxt = STOPPING;
      else if (state == STOPPING) state_nxt = enable ? ACTIVE : (!infl && occ == 2'd0) ? IDLE : STOPPING;
   end
   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         state <= IDLE;
         occ <= 2'd0;
         infl <= 1'b0;
         hd <= 1'b0;
         ent[0] <= '0;
         ent[1] <= '0;
         word_count <= '0;
         checksum <= '0;
      end else begin
         assert (!(infl && occ == 2'd2 && !pop));
         state <= state_nxt;
         occ <= occ_nxt;
         infl <= r_inc;
         hd <= hd ^ pop;
         if (infl) ent[hd ^ occ[0]] <= r_data;
         if (clr_stats) begin
            word_count <= '0;
            checksum <= '0;
         end else if (pop) begin
            word_count <= word_count + CNT_W'(1);
            checksum <= checksum + out_data;
         end
      end
   end
endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// tb_async_fifo_rd_drain: directed bench with a FIFO model and an in-order scoreboard of delivered words
module tb_async_fifo_rd_drain;
   logic r_clk = 1'b0;
   logic r_rst, r_empty, r_inc, enable, out_valid, out_ready, clr_stats, busy;
   logic [7:0] r_data, out_data, checksum;
   logic [3:0] word_count;
   logic [7:0] fifo [$];
   logic [7:0] exp_q [$];
   logic [3:0] m_cnt;
   logic [7:0] m_sum;
   int n_chk, n_fail, cyc, npop, ntx, first_inc, first_valid, first_tx, last_tx;

   async_fifo_rd_drain #(.D_SIZE(8), .CNT_W(4)) dut (
      .r_clk(r_clk), .r_rst(r_rst), .r_data(r_data), .r_empty(r_empty), .r_inc(r_inc),
      .enable(enable), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .clr_stats(clr_stats), .word_count(word_count), .checksum(checksum), .busy(busy)
   );

   always #5 r_clk = ~r_clk;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic load(logic [7:0] w);
      fifo.push_back(w);
      exp_q.push_back(w);
      r_empty = 1'b0;
   endtask

   // one clock: observe the cycle at negedge, then apply FIFO read data after the edge
   task automatic step();
      logic got;
      logic [7:0] d_p, d_e;
      got = 1'b0;
      d_p = '0;
      @(negedge r_clk);
      cyc++;
      if (r_rst) begin
         m_cnt = '0;
         m_sum = '0;
      end else begin
         if (r_inc) begin
            check("pop_nonempty", 32'(fifo.size() != 0), 32'd1);
            if (fifo.size() != 0) begin
               d_p = fifo.pop_front();
               got = 1'b1;
            end
            npop++;
            if (first_inc < 0) first_inc = cyc;
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && out_ready) begin
            if (first_tx < 0) first_tx = cyc;
            last_tx = cyc;
            ntx++;
            if (exp_q.size() != 0) d_e = exp_q.pop_front();
            else d_e = 'x;
            check("tx_data", 32'(out_data), 32'(d_e));
            if (!clr_stats) begin
               m_cnt = m_cnt + 4'd1;
               m_sum = m_sum + out_data;
            end
         end
         if (clr_stats) begin
            m_cnt = '0;
            m_sum = '0;
         end
      end
      @(posedge r_clk);
      #1;
      if (got) r_data = d_p;
      r_empty = fifo.size() == 0;
   endtask

   task automatic wait_tx(int target, int budget, string tag);
      for (int i = 0; i < budget && ntx < target; i++) step();
      check(tag, 32'(ntx), 32'(target));
   endtask

   task automatic wait_idle(int budget, string tag);
      for (int i = 0; i < budget && busy; i++) step();
      check(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      r_rst = 1'b1;
      enable = 1'b0;
      out_ready = 1'b0;
      clr_stats = 1'b0;
      r_empty = 1'b1;
      r_data = '0;
      m_cnt = '0;
      m_sum = '0;
      {n_chk, n_fail, cyc, npop, ntx} = '0;
      load(8'h55);
      load(8'h66);
      repeat (3) step();
      check("rst_rinc", 32'(r_inc), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cnt", 32'(word_count), 32'd0);
      check("rst_sum", 32'(checksum), 32'd0);
      r_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_rinc", 32'(r_inc), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
      end
      fifo.delete();
      exp_q.delete();
      r_empty = 1'b1;
      // streaming 0x01..0x10
      first_inc = -1;
      first_valid = -1;
      first_tx = -1;
      last_tx = -1;
      ntx = 0;
      for (int i = 1; i <= 16; i++) load(8'(i));
      out_ready = 1'b1;
      enable = 1'b1;
      wait_tx(16, 40, "stream_done");
      check("stream_latency", 32'(first_valid - first_inc), 32'd2);
      check("stream_b2b", 32'(last_tx - first_tx), 32'd15);
      check("stream_cnt", 32'(word_count), 32'd0);
      check("stream_sum", 32'(checksum), 32'h88);
      enable = 1'b0;
      wait_idle(10, "stream_idle");
      check("stream_valid_off", 32'(out_valid), 32'd0);
      // back-pressure
      out_ready = 1'b0;
      ntx = 0;
      npop = 0;
      enable = 1'b1;
      for (int i = 0; i < 10; i++) load(8'h21 + 8'(i));
      repeat (10) step();
      check("bp_pops", 32'(npop), 32'd2);
      check("bp_rinc", 32'(r_inc), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_head", 32'(out_data), 32'h21);
      out_ready = 1'b1;
      #1;
      check("bp_reissue", 32'(r_inc), 32'd1);
      for (int i = 0; i < 60 && ntx < 10; i++) begin
         step();
         out_ready = ~out_ready;
      end
      check("bp_done", 32'(ntx), 32'd10);
      out_ready = 1'b1;
      check("bp_cnt", 32'(word_count), 32'd10);
      check("bp_sum", 32'(checksum), 32'hff);
      // empty boundary
      for (int i = 0; i < 3; i++) begin
         step();
         check("empty_rinc", 32'(r_inc), 32'd0);
      end
      ntx = 0;
      load(8'haa);
      wait_tx(1, 10, "aa_tx");
      repeat (3) step();
      check("aa_once", 32'(ntx), 32'd1);
      check("aa_cnt", 32'(word_count), 32'd11);
      check("aa_sum", 32'(checksum), 32'ha9);
      // stop with one word buffered and one in flight, then restart
      ntx = 0;
      npop = 0;
      for (int i = 0; i < 8; i++) load(8'h31 + 8'(i));
      step();
      step();
      check("stop_pre_valid", 32'(out_valid), 32'd1);
      enable = 1'b0;
      #1;
      check("stop_rinc", 32'(r_inc), 32'd0);
      check("stop_busy", 32'(busy), 32'd1);
      wait_idle(10, "stop_idle");
      check("stop_pops", 32'(npop), 32'd2);
      check("stop_tx", 32'(ntx), 32'd2);
      check("stop_left", 32'(fifo.size()), 32'd6);
      enable = 1'b1;
      wait_tx(8, 30, "restart_tx");
      check("restart_drained", 32'(exp_q.size()), 32'd0);
      // wrap and clear
      clr_stats = 1'b1;
      step();
      clr_stats = 1'b0;
      check("clr_cnt", 32'(word_count), 32'd0);
      check("clr_sum", 32'(checksum), 32'd0);
      ntx = 0;
      load(8'hff);
      load(8'h02);
      wait_tx(2, 10, "wrap_tx");
      check("wrap_sum", 32'(checksum), 32'h01);
      check("wrap_cnt2", 32'(word_count), 32'd2);
      for (int i = 1; i <= 15; i++) load(8'(i));
      wait_tx(17, 40, "wrap17_tx");
      check("wrap_cnt", 32'(word_count), 32'd1);
      check("wrap17_sum", 32'(checksum), 32'h79);
      ntx = 0;
      load(8'h41);
      load(8'h42);
      load(8'h43);
      for (int i = 0; i < 10 && !out_valid; i++) step();
      clr_stats = 1'b1;
      check("clrx_in_tx", 32'(out_valid && out_ready), 32'd1);
      step();
      clr_stats = 1'b0;
      check("clrx_cnt", 32'(word_count), 32'd0);
      check("clrx_sum", 32'(checksum), 32'd0);
      wait_tx(3, 10, "clrx_tx");
      check("clrx_cnt2", 32'(word_count), 32'd2);
      check("clrx_sum2", 32'(checksum), 32'h85);
      check("model_cnt", 32'(word_count), 32'(m_cnt));
      check("model_sum", 32'(checksum), 32'(m_sum));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
